// File: rtl/fir_pkg.sv
// Shared FIR defaults and the accumulator sizing helper.
// The accumulator is wide enough to hold the sum of all full-width products without overflow.
package fir_pkg;

  localparam int DEFAULT_N      = 32;
  localparam int DEFAULT_DELAYS = 3;

  function automatic int acc_width(input int n, input int delays);
    return 2 * n + $clog2(delays + 1);
  endfunction

endpackage

// File: rtl/clk_divider.sv
// Sample-rate generator: a 50% duty square wave at CLK_HZ/DESIRED_HZ clk cycles per period.
// Output is registered and starts low; the first rise follows CLK_COUNTER/2 edges after reset.
module clk_divider #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int DESIRED_HZ = 48_000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_d
);

  localparam int CLK_COUNTER = CLK_HZ / DESIRED_HZ;
  localparam int HALF        = CLK_COUNTER / 2;
  localparam int CW          = $clog2(HALF + 1);

  logic [CW-1:0] r_cnt;
  logic          r_clk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_clk_d <= 1'b0;
    end else if (r_cnt == CW'(HALF - 1)) begin
      r_cnt   <= '0;
      r_clk_d <= ~r_clk_d;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign clk_d = r_clk_d;

endmodule

// File: rtl/fir_n.sv
// Direct-form FIR with DELAYS+1 taps, one multiply-accumulate pass per sample tick.
// The output and delay line update one clk after clk_d rises; with no tick or ena low, they hold.
module fir_n
  import fir_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DELAYS = DEFAULT_DELAYS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_d,
  input  logic                       ena,
  input  logic signed [N-1:0]        x_in,
  input  logic [(DELAYS+1)*N-1:0]    b,
  output logic signed [N-1:0]        y_out
);

  localparam int PW    = 2 * N;
  localparam int ACC_W = acc_width(N, DELAYS);

  logic                r_clk_d;
  logic                w_tick;
  logic signed [N-1:0] r_dly  [1:DELAYS];
  logic signed [N-1:0] w_tap  [0:DELAYS];
  logic signed [PW-1:0] w_prod [0:DELAYS];
  logic signed [ACC_W-1:0] w_acc;
  logic                w_unused_acc;

  assign w_tick = clk_d & ~r_clk_d;

  // Tap 0 is the live input; tap k is the sample seen k ticks ago.
  for (genvar k = 0; k <= DELAYS; k++) begin : g_tap
    if (k == 0) begin : g_cur
      assign w_tap[k] = x_in;
    end else begin : g_old
      assign w_tap[k] = r_dly[k];
    end
    assign w_prod[k] = PW'($signed(b[k*N +: N])) * PW'(w_tap[k]);
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k <= DELAYS; k++) begin
      w_acc = w_acc + ACC_W'(w_prod[k]);
    end
  end

  assign w_unused_acc = ^w_acc[ACC_W-1:N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_d <= 1'b0;
      y_out   <= '0;
      for (int k = 1; k <= DELAYS; k++) begin
        r_dly[k] <= '0;
      end
    end else begin
      r_clk_d <= clk_d;
      if (w_tick && ena) begin
        y_out <= w_acc[N-1:0];
        for (int k = 1; k <= DELAYS; k++) begin
          r_dly[k] <= w_tap[k-1];
        end
      end
    end
  end

`ifndef SYNTHESIS
  task automatic print_io();
    $display("fir_n x_in=%0d y_out=%0d", x_in, y_out);
  endtask
`endif

endmodule

// File: tb/tb_fir_n.sv
// Directed bench for fir_n driven by clk_divider: reset, divider timing, impulse, step, sign, enable, wrap.
module tb_fir_n;
  import fir_pkg::*;

  localparam int N      = DEFAULT_N;
  localparam int DELAYS = DEFAULT_DELAYS;

  logic                    clk;
  logic                    rst;
  logic                    clk_d;
  logic                    ena;
  logic signed [N-1:0]     x_in;
  logic [(DELAYS+1)*N-1:0] b;
  logic signed [N-1:0]     y_out;

  int n_tot;
  int n_bad;

  clk_divider u_div (
    .clk   (clk),
    .rst   (rst),
    .clk_d (clk_d)
  );

  fir_n #(.N(N), .DELAYS(DELAYS)) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_d (clk_d),
    .ena   (ena),
    .x_in  (x_in),
    .b     (b),
    .y_out (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_b(input int c0, input int c1, input int c2, input int c3);
    logic signed [N-1:0] t0, t1, t2, t3;
    t0 = N'(c0); t1 = N'(c1); t2 = N'(c2); t3 = N'(c3);
    b = {t3, t2, t1, t0};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Returns #1 after the clk edge on which a tick is taken (one clk after clk_d rises).
  task automatic wait_update(input string tag);
    logic p;
    int   n;
    bit   seen;
    p    = clk_d;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (clk_d && !p) seen = 1'b1;
      p = clk_d;
    end
    if (!seen) chk({tag, "_timeout"}, 64'(n), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int h;
    int l;
    int imp [4];
    int stp [5];
    int sgn [4];

    n_tot = 0;
    n_bad = 0;
    rst   = 1'b0;
    ena   = 1'b1;
    x_in  = '0;
    set_b(193, 376, 376, 193);

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_y", y_out, 0);
    chk("rst_clkd", clk_d, 0);

    // Divider timing from reset release
    rst = 1'b1;
    c = 0;
    while (!clk_d && c < 1000) begin @(posedge clk); #1; c++; end
    chk("div_first_rise", c, 125);
    h = 0;
    while (clk_d && h < 1000) begin @(posedge clk); #1; h++; end
    chk("div_high", h, 125);
    l = 0;
    while (!clk_d && l < 1000) begin @(posedge clk); #1; l++; end
    chk("div_period", h + l, 250);

    // Impulse
    imp = '{193000, 376000, 376000, 193000};
    do_reset();
    x_in = 1000;
    for (int i = 0; i < 4; i++) begin
      wait_update("imp");
      x_in = 0;
      chk($sformatf("imp_%0d", i), y_out, imp[i]);
    end
    for (int i = 0; i < 2; i++) begin
      wait_update("imp_tail");
      chk($sformatf("imp_tail_%0d", i), y_out, 0);
    end
    dut.print_io();

    // Step
    stp = '{193, 569, 945, 1138, 1138};
    do_reset();
    x_in = 1;
    for (int i = 0; i < 5; i++) begin
      wait_update("step");
      chk($sformatf("step_%0d", i), y_out, stp[i]);
    end

    // Negative impulse with a negative coefficient
    sgn = '{-193000, 376000, -376000, -193000};
    do_reset();
    set_b(193, -376, 376, 193);
    x_in = -1000;
    for (int i = 0; i < 4; i++) begin
      wait_update("sgn");
      x_in = 0;
      chk($sformatf("sgn_%0d", i), y_out, sgn[i]);
    end

    // Enable freeze mid-impulse: nothing lost or repeated on resume
    do_reset();
    set_b(193, 376, 376, 193);
    x_in = 1000;
    wait_update("ena");
    chk("ena_first", y_out, 193000);
    ena  = 1'b0;
    x_in = 7;
    for (int i = 0; i < 3; i++) begin
      wait_update("ena_frz");
      chk($sformatf("ena_hold_%0d", i), y_out, 193000);
    end
    x_in = 0;
    ena  = 1'b1;
    wait_update("ena_r");
    chk("ena_res_0", y_out, 376000);
    wait_update("ena_r");
    chk("ena_res_1", y_out, 376000);
    wait_update("ena_r");
    chk("ena_res_2", y_out, 193000);
    wait_update("ena_r");
    chk("ena_res_3", y_out, 0);

    // Wrap to low N bits, then asynchronous reset mid-response
    do_reset();
    set_b(4, 0, 0, 0);
    x_in = 32'sh4000_0000;
    wait_update("wrap");
    chk("wrap_zero", y_out, 0);
    x_in = 32'sh4000_0001;
    wait_update("wrap");
    chk("wrap_four", y_out, 4);
    x_in = 1000;
    wait_update("wrap");
    chk("pre_arst", y_out, 4000);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_y", y_out, 0);
    chk("arst_clkd", clk_d, 0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_n.md
FIR_N -- requirements
Module: fir_n

Interface
REQ-001 Parameter N, default 32: signed sample and coefficient width in bits.
REQ-002 Parameter DELAYS, default 3: number of unit (z^-1) delays; the filter has DELAYS+1 taps.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 clk_d  input  1  sample-rate signal generated in the clk domain by clk_divider; used only as data, never as a clock.
REQ-007 ena  input  1  filter enable.
REQ-008 x_in  input  N  signed input sample.
REQ-009 b  input  (DELAYS+1)*N  packed signed coefficients: bits [N-1:0] hold b0 (current sample); slice k holds bk (k delays); the top slice holds b_DELAYS.
REQ-010 y_out  output  N  signed filter output, registered.

Function
REQ-011 fir_n SHALL register clk_d each clk cycle and form sample_tick = clk_d AND NOT (registered clk_d).
REQ-012 On a clk edge with sample_tick=1 and ena=1, y_out SHALL load sum over k=0..DELAYS of bk*x[n-k]: x[n] is the current x_in, x[n-k] is delay-line entry k.
REQ-013 On the same edge, the delay line SHALL shift: entry 1 takes x_in, entry k takes entry k-1, and the oldest value is discarded.
REQ-014 y_out and the delay line SHALL update exactly one clk cycle after clk_d rises, once per clk_d period.
REQ-015 Arithmetic SHALL be signed two's complement: full 2N-bit products, accumulator of 2N+clog2(DELAYS+1) bits, and y_out = low N bits of the sum (wrap, no saturation, no scaling).
REQ-016 When ena=0 or sample_tick=0, y_out and the delay line SHALL hold their values.
REQ-017 Changes on b take effect at the next sample_tick; b is not registered.
REQ-018 fir_n SHALL provide a simulation-only task print_io that displays x_in and y_out as signed decimals.
REQ-019 clk_divider parameters: CLK_HZ (default 12_000_000) and DESIRED_HZ (default 48_000); CLK_COUNTER = CLK_HZ/DESIRED_HZ.
REQ-020 clk_divider ports are clk, rst and clk_d (output, 1 bit).
REQ-021 clk_divider SHALL toggle clk_d every CLK_COUNTER/2 clk cycles, giving a 50% duty cycle and a period of 250 clk cycles at the defaults.

Reset
REQ-022 While rst=0, y_out, every delay-line entry and the registered clk_d SHALL be 0.
REQ-023 While rst=0, the clk_divider counter and its clk_d output SHALL be 0.
REQ-024 After rst is released, the first sample_tick SHALL occur at the first rising edge of clk_d.
REQ-025 An assertion of rst mid-operation SHALL clear all state immediately, independent of clk.

Structure
REQ-026 A shared package fir_pkg SHALL hold the default N and DELAYS values and a helper function for the accumulator width; no typedefs are required.
REQ-027 clk_divider SHALL be the single sub-module; the bench instantiates it alongside fir_n and connects its clk_d output to fir_n clk_d.
REQ-028 The delay line and products SHALL be built with generate loops indexed over DELAYS.

Verification
REQ-029 Reset: hold rst=0 -> y_out=0 and clk_d=0; after release, clk_d period=250 clk cycles with a high time of 125 cycles.
REQ-030 Impulse: b={193,376,376,193}, x_in=1000 for one sample then 0 -> y_out=193000, 376000, 376000, 193000, then 0 for every later sample.
REQ-031 Step: same b, x_in=1 held -> y_out=193, 569, 945, 1138, then 1138 for every later sample.
REQ-032 Sign: x_in=-1000 impulse with b1=-376 -> y_out=-193000, then +376000, then -376000, then -193000.
REQ-033 Enable: ena=0 for 3 clk_d periods mid-stream -> y_out and the delay line are frozen; after ena=1 the sequence resumes with no lost or duplicated sample.
REQ-034 Wrap: b0=4, x_in=2^30 -> y_out=0 (low N bits of the sum); rst asserted mid-response clears y_out at once.
